// File: rtl/cpu_pkg.sv
// Shared CPU types: FSM state set, instruction classes, opcode/ALU/immediate codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_TRAP
    } mc_state_t;

    typedef enum logic [2:0] {
        CLS_ADDI,
        CLS_ADD,
        CLS_BEQ,
        CLS_BNE,
        CLS_LW,
        CLS_SW
    } instr_class_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_CMP = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/instr_class_decode.sv
// Classifies a 32-bit RV32I instruction word into one of the supported classes.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows input.
// Ports: i_instr (instruction word), o_class (instruction class), o_legal (1 = supported encoding).
module instr_class_decode
    import cpu_pkg::*;
(
    input  logic [31:0]  i_instr,
    output instr_class_t o_class,
    output logic         o_legal
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_unused;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];
    // Register and immediate fields do not affect classification.
    assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        o_class = CLS_ADD;
        o_legal = 1'b0;
        case (w_opcode)
            OP_IMM: begin
                if (w_f3 == 3'b000) begin
                    o_class = CLS_ADDI;
                    o_legal = 1'b1;
                end
            end
            OP_REG: begin
                if (w_f3 == 3'b000 && w_f7 == 7'b0000000) begin
                    o_class = CLS_ADD;
                    o_legal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (w_f3 == 3'b000) begin
                    o_class = CLS_BEQ;
                    o_legal = 1'b1;
                end else if (w_f3 == 3'b001) begin
                    o_class = CLS_BNE;
                    o_legal = 1'b1;
                end
            end
            OP_LOAD: begin
                if (w_f3 == 3'b010) begin
                    o_class = CLS_LW;
                    o_legal = 1'b1;
                end
            end
            OP_STORE: begin
                if (w_f3 == 3'b010) begin
                    o_class = CLS_SW;
                    o_legal = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/mem/writeback with trap on unsupported encodings.
// Latency: branch 3, ADD/ADDI 4, SW 4, LW 5 cycles; each cycle without dmem_ready adds one.
// Backpressure: waits indefinitely in FETCH for imem_ready and in MEM for dmem_ready.
// Ports: clk/rst_n; imem_rdata/imem_ready from instruction memory; dmem_ready from data memory;
//        EQ from ALU; instr (IR), ALU/immediate selects, memory/regfile/PC strobes, illegal, instret.
module mc_control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_ready,
    input  logic                  dmem_ready,
    input  logic                  EQ,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [2:0]            ALUctrl,
    output logic                  ALUsrc,
    output logic [1:0]            ImmSrc,
    output logic                  IRwrite,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  ResultSrc,
    output logic                  RegWrite,
    output logic                  PCwrite,
    output logic                  PCsrc,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  instret
);

    mc_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [CNT_WIDTH-1:0]  r_instret;
    instr_class_t          w_class;
    logic                  w_legal;

    instr_class_decode u_decode (
        .i_instr (r_instr[31:0]),
        .o_class (w_class),
        .o_legal (w_legal)
    );

    assign instr   = r_instr;
    assign instret = r_instret;

    // Outputs decode from state and IR; gated by rst_n so nothing leaks while reset is held,
    // including IRwrite in FETCH with imem_ready high.
    always_comb begin
        ALUctrl   = ALU_ADD;
        ALUsrc    = 1'b0;
        ImmSrc    = IMM_I;
        IRwrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ResultSrc = 1'b0;
        RegWrite  = 1'b0;
        PCwrite   = 1'b0;
        PCsrc     = 1'b0;
        illegal   = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH: IRwrite = imem_ready;
                ST_EXECUTE: begin
                    case (w_class)
                        CLS_ADDI, CLS_LW: ALUsrc = 1'b1;
                        CLS_SW: begin
                            ALUsrc = 1'b1;
                            ImmSrc = IMM_S;
                        end
                        CLS_BEQ, CLS_BNE: begin
                            ALUctrl = ALU_CMP;
                            ImmSrc  = IMM_B;
                            PCwrite = 1'b1;
                            PCsrc   = (w_class == CLS_BEQ) ? EQ : !EQ;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    // Address operands stay selected for the whole memory access.
                    ALUsrc = 1'b1;
                    if (w_class == CLS_SW) begin
                        ImmSrc   = IMM_S;
                        MemWrite = 1'b1;
                        PCwrite  = dmem_ready;
                    end else begin
                        MemRead = 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    RegWrite  = 1'b1;
                    ResultSrc = (w_class == CLS_LW);
                    PCwrite   = 1'b1;
                end
                ST_TRAP: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_instr   <= '0;
            r_instret <= '0;
        end else begin
            // Exactly one PCwrite cycle per retired instruction.
            if (PCwrite) begin
                r_instret <= r_instret + CNT_WIDTH'(1);
            end
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: r_state <= w_legal ? ST_EXECUTE : ST_TRAP;
                ST_EXECUTE: begin
                    case (w_class)
                        CLS_BEQ, CLS_BNE: r_state <= ST_FETCH;
                        CLS_LW, CLS_SW:   r_state <= ST_MEM;
                        default:          r_state <= ST_WRITEBACK;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        r_state <= (w_class == CLS_LW) ? ST_WRITEBACK : ST_FETCH;
                    end
                end
                ST_WRITEBACK: r_state <= ST_FETCH;
                ST_TRAP:      r_state <= ST_TRAP;
                default:      r_state <= ST_TRAP;
            endcase
        end
    end

endmodule
